// File: rtl/mips_state_sequencer.sv
`default_nettype none
// ============================================================================
// mips_state_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB/HALT sequencer.
// Optional waitrequest watchdog: define SEQ_WAIT_WATCHDOG_EN.  Revision 1.0
// ============================================================================
module mips_state_sequencer #(
  parameter int WAIT_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func_code,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             waitrequest,
  input  logic             md_busy,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             active,
  output logic             stall,
  output logic             md_start,
  output logic [CNT_W-1:0] instr_count,
  output logic             bus_error
);

  typedef enum logic [2:0] {
    FETCH_INSTR   = 3'b000,
    DECODE        = 3'b001,
    EXECUTE       = 3'b010,
    MEMORY_ACCESS = 3'b011,
    WRITE_BACK    = 3'b100,
    HALT          = 3'b101
  } state_t;

  state_t           state_q, state_d;
  logic             md_started_q, md_started_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             is_load, is_md, mem_phase, mem_stall;
  logic             hold, retire, timeout, md_start_c;

  // Loads are 100000..100110; 100111 is not a load.
  assign is_load   = (opcode[5:3] == 3'b100) && (opcode[2:0] != 3'b111);
  assign is_md     = (opcode == 6'b000000) && (func_code[5:2] == 4'b0110);
  assign mem_phase = (state_q == FETCH_INSTR) || (state_q == MEMORY_ACCESS);
  assign mem_stall = mem_phase && (mem_read || mem_write) && waitrequest;

`ifdef SEQ_WAIT_WATCHDOG_EN
  localparam int WAIT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bus_error_q, bus_error_d;

  assign timeout = mem_stall && ((32'(wait_cnt_q) + 32'd1) >= 32'(WAIT_TIMEOUT));

  always_comb begin
    wait_cnt_d  = '0;
    bus_error_d = bus_error_q;
    if (timeout) begin
      bus_error_d = 1'b1;
    end else if (mem_stall) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;
`else
  logic unused_wait_cfg;

  assign unused_wait_cfg = (WAIT_TIMEOUT == 0);
  assign timeout         = 1'b0;
  assign bus_error       = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    md_started_d = md_started_q;
    md_start_c   = 1'b0;
    hold         = 1'b0;
    retire       = 1'b0;
    case (state_q)
      FETCH_INSTR: begin
        if (timeout)        state_d = HALT;
        else if (mem_stall) hold    = 1'b1;
        else                state_d = DECODE;
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        if (!is_md) begin
          state_d = MEMORY_ACCESS;
        end else if (!md_started_q) begin
          md_start_c   = 1'b1;
          md_started_d = 1'b1;
          hold         = 1'b1;
        end else if (md_busy) begin
          hold = 1'b1;
        end else begin
          md_started_d = 1'b0;
          state_d      = MEMORY_ACCESS;
        end
      end
      MEMORY_ACCESS: begin
        if (timeout) begin
          state_d = HALT;
        end else if (mem_stall) begin
          hold = 1'b1;
        end else if (is_load) begin
          state_d = WRITE_BACK;
        end else begin
          retire  = 1'b1;
          state_d = halt_req ? HALT : FETCH_INSTR;
        end
      end
      WRITE_BACK: begin
        retire  = 1'b1;
        state_d = halt_req ? HALT : FETCH_INSTR;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH_INSTR;
    endcase
    count_d = retire ? count_q + 1'b1 : count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH_INSTR;
      md_started_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      md_started_q <= md_started_d;
      count_q      <= count_d;
    end
  end

  // Combinational strobes are masked while reset is held so reset wins outright.
  assign state       = state_q;
  assign active      = (state_q != HALT);
  assign stall       = hold && !reset;
  assign md_start    = md_start_c && !reset;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_state_sequencer.sv
`default_nettype none
// Bench for mips_state_sequencer: per-instruction trace model plus a per-cycle compare.
module tb_mips_state_sequencer;
  localparam int CNT_W        = 3;
  localparam int WAIT_TIMEOUT = 8;
  localparam logic [2:0] S_FETCH = 3'd0, S_DEC = 3'd1, S_EXE = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode, func_code;
  logic             mem_read, mem_write, waitrequest, md_busy, halt_req;
  logic [2:0]       state;
  logic             active, stall, md_start, bus_error;
  logic [CNT_W-1:0] instr_count;

  mips_state_sequencer #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
    .mem_read(mem_read), .mem_write(mem_write), .waitrequest(waitrequest),
    .md_busy(md_busy), .halt_req(halt_req), .state(state), .active(active),
    .stall(stall), .md_start(md_start), .instr_count(instr_count), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int         pass_cnt = 0, total_cnt = 0;
  int         model_count = 0;
  bit         exp_valid = 1'b0;
  logic [2:0] exp_state;
  logic       exp_stall, exp_md_start, exp_active, exp_bus_error = 1'b0;
  int         exp_count;
  int         hist[8];
  int         md_pulses;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("state", 32'(state), 32'(exp_state));
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("md_start", 32'(md_start), 32'(exp_md_start));
      chk("active", 32'(active), 32'(exp_active));
      chk("instr_count", 32'(instr_count), exp_count);
      chk("bus_error", 32'(bus_error), 32'(exp_bus_error));
      hist[state] = hist[state] + 1;
      if (md_start) md_pulses++;
    end
  end

  function automatic bit m_is_load(input logic [5:0] op);
    return op inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
  endfunction

  function automatic bit m_is_md(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00) && (fn inside {6'h18, 6'h19, 6'h1a, 6'h1b});
  endfunction

  task automatic clear_obs();
    for (int i = 0; i < 8; i++) hist[i] = 0;
    md_pulses = 0;
  endtask

  function automatic int hist_sum();
    int s = 0;
    for (int i = 0; i < 8; i++) s += hist[i];
    return s;
  endfunction

  // One expected clock cycle: inputs already driven; expectations apply until the next edge.
  task automatic cyc(input logic [2:0] s, input logic st, input logic ms);
    exp_state    = s;
    exp_stall    = st;
    exp_md_start = ms;
    exp_active   = (s != S_HALT);
    exp_count    = model_count;
    exp_valid    = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    mem_read = 1'b1; mem_write = 1'b0; waitrequest = 1'b0; md_busy = 1'b0; halt_req = 1'b0;
  endtask

  // Whole-instruction trace from the ISA-level rules. noise drives irrelevant inputs high.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input int mb, input bit hlt, input bit noise);
    bit ld  = m_is_load(op);
    bit md  = m_is_md(op, fn);
    bit acc = ld || (op inside {6'h28, 6'h29, 6'h2b});
    opcode = op; func_code = fn;
    mem_read = 1'b1; mem_write = 1'b0; md_busy = noise; halt_req = noise;
    for (int i = 0; i < fw; i++) begin waitrequest = 1'b1; cyc(S_FETCH, 1'b1, 1'b0); end
    waitrequest = 1'b0; cyc(S_FETCH, 1'b0, 1'b0);
    mem_read = noise; waitrequest = noise;
    cyc(S_DEC, 1'b0, 1'b0);
    if (md) begin
      md_busy = 1'b0; cyc(S_EXE, 1'b1, 1'b1);
      md_busy = 1'b1;
      for (int i = 0; i < mb; i++) cyc(S_EXE, 1'b1, 1'b0);
      md_busy = 1'b0; cyc(S_EXE, 1'b0, 1'b0);
    end else begin
      cyc(S_EXE, 1'b0, 1'b0);
    end
    md_busy = noise; mem_read = ld; mem_write = acc && !ld;
    if (acc) begin
      for (int i = 0; i < mw; i++) begin
        waitrequest = 1'b1; halt_req = noise || (hlt && !ld);
        cyc(S_MEM, 1'b1, 1'b0);
      end
    end
    waitrequest = acc ? 1'b0 : noise;
    if (!ld) begin
      halt_req = hlt; cyc(S_MEM, 1'b0, 1'b0);
    end else begin
      halt_req = noise; cyc(S_MEM, 1'b0, 1'b0);
      mem_read = 1'b0; waitrequest = noise; halt_req = hlt;
      cyc(S_WB, 1'b0, 1'b0);
    end
    model_count = (model_count + 1) % (1 << CNT_W);
    idle_inputs();
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      opcode = 6'($urandom); func_code = 6'($urandom);
      mem_read = 1'($urandom); mem_write = 1'($urandom); waitrequest = 1'($urandom);
      md_busy = 1'($urandom); halt_req = 1'($urandom);
      cyc(S_HALT, 1'b0, 1'b0);
    end
    idle_inputs();
  endtask

  task automatic do_reset(input logic [2:0] cur);
    reset = 1'b1;
    cyc(cur, 1'b0, 1'b0);
    reset = 1'b0;
    model_count   = 0;
    exp_bus_error = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; opcode = 6'h00; func_code = 6'h00;
    idle_inputs();
    @(posedge clk); #1;
    cyc(S_FETCH, 1'b0, 1'b0);                 // reset still held: all reset values
    reset = 1'b0;

    clear_obs();
    run_instr(6'h00, 6'h21, 0, 0, 0, 1'b0, 1'b0);   // ADDU
    chk("addu_cycles", hist_sum(), 4);
    chk("addu_count", 32'(instr_count), 1);

    clear_obs();
    run_instr(6'h23, 6'h00, 0, 3, 0, 1'b0, 1'b0);   // LW, 3 wait cycles
    chk("lw_mem_cycles", hist[3], 4);
    chk("lw_cycles", hist_sum(), 8);
    chk("lw_count", 32'(instr_count), 2);

    clear_obs();
    run_instr(6'h00, 6'h18, 0, 0, 5, 1'b0, 1'b0);   // MULT, busy 5
    chk("mult_exec_cycles", hist[2], 7);
    chk("mult_md_pulses", md_pulses, 1);
    chk("mult_count", 32'(instr_count), 3);

    run_instr(6'h2b, 6'h00, 2, 2, 0, 1'b0, 1'b0);   // SW with fetch and mem waits
    clear_obs();
    run_instr(6'h3f, 6'h00, 0, 0, 0, 1'b0, 1'b1);   // undefined opcode, noisy inputs
    chk("undef_cycles", hist_sum(), 4);
    clear_obs();
    run_instr(6'h00, 6'h1b, 0, 0, 0, 1'b0, 1'b1);   // DIVU, no busy: two EXECUTE cycles
    chk("divu_exec_cycles", hist[2], 2);
    run_instr(6'h20, 6'h00, 7, 5, 0, 1'b0, 1'b1);   // LB, 7 fetch waits stays under timeout
    clear_obs();
    run_instr(6'h27, 6'h00, 0, 0, 0, 1'b0, 1'b0);   // 100111 is not a load
    chk("op27_cycles", hist_sum(), 4);
    chk("count_wrap", 32'(instr_count), 0);
    run_instr(6'h00, 6'h21, 0, 0, 0, 1'b0, 1'b0);

    // Reset while FETCH is stalled on waitrequest
    opcode = 6'h00; func_code = 6'h21; waitrequest = 1'b1;
    cyc(S_FETCH, 1'b1, 1'b0);
    cyc(S_FETCH, 1'b1, 1'b0);
    do_reset(S_FETCH);
    waitrequest = 1'b0;
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(instr_count), 0);
    chk("rst_active", 32'(active), 1);
    chk("rst_stall", 32'(stall), 0);

    // Halt requested during a stalled store: stall first, halt on completion
    run_instr(6'h2b, 6'h00, 0, 2, 0, 1'b1, 1'b0);
    halt_cycles(3);
    do_reset(S_HALT);

    run_instr(6'h00, 6'h21, 0, 0, 0, 1'b0, 1'b0);
    run_instr(6'h00, 6'h08, 0, 0, 0, 1'b1, 1'b0);   // JR with halt
    halt_cycles(20);
    chk("halt_count", 32'(instr_count), 2);
    chk("halt_active", 32'(active), 0);
    do_reset(S_HALT);

    opcode = 6'h00; func_code = 6'h21; mem_read = 1'b1; waitrequest = 1'b1;
`ifdef SEQ_WAIT_WATCHDOG_EN
    for (int i = 0; i < WAIT_TIMEOUT - 1; i++) cyc(S_FETCH, 1'b1, 1'b0);
    cyc(S_FETCH, 1'b0, 1'b0);
    exp_bus_error = 1'b1;
    halt_cycles(5);
    chk("wd_state", 32'(state), 5);
    chk("wd_bus_error", 32'(bus_error), 1);
    chk("wd_active", 32'(active), 0);
`else
    for (int i = 0; i < 100; i++) cyc(S_FETCH, 1'b1, 1'b0);
    chk("nowd_state", 32'(state), 0);
    chk("nowd_bus_error", 32'(bus_error), 0);
    chk("nowd_stall", 32'(stall), 1);
`endif
    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mips_state_sequencer.md
Name: mips_state_sequencer

Overview:
- Multi-cycle state sequencer for the Avalon-MM MIPS CPU.
- Produces the 3-bit `state` consumed by the combinational control decoder.
- Holds the current state while an Avalon transfer is stalled or a MULT/DIV operation is busy.
- Starts the multiply/divide unit, stops the core when the datapath requests a halt, and counts retired instructions.

Parameters:
- WAIT_TIMEOUT, 255: maximum number of consecutive waitrequest stall cycles allowed before a bus error. Used only with the optional feature.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction bits [31:26], taken from the instruction register
- func_code  in  6  instruction bits [5:0]
- mem_read  in  1  read strobe from the control decoder for the current state
- mem_write  in  1  write strobe from the control decoder for the current state
- waitrequest  in  1  Avalon waitrequest
- md_busy  in  1  multiply/divide unit is still computing
- halt_req  in  1  datapath requests a stop (PC reached 0 after the delay slot)
- state  out  3  current state: 000 FETCH_INSTR, 001 DECODE, 010 EXECUTE, 011 MEMORY_ACCESS, 100 WRITE_BACK, 101 HALT
- active  out  1  core is running
- stall  out  1  state is being held this cycle
- md_start  out  1  one-cycle start pulse to the multiply/divide unit
- instr_count  out  CNT_W  number of retired instructions
- bus_error  out  1  waitrequest timeout (optional feature only; tied to 0 otherwise)

Behaviour:
- Reset values (synchronous, takes priority over everything, including mid-transfer): state=FETCH_INSTR, active=1, stall=0, md_start=0, instr_count=0, bus_error=0, wait counter=0, md_started flag=0.
- Definitions:
  - is_load: opcode in {100000, 100001, 100010, 100011, 100100, 100101, 100110}.
  - is_md: opcode==000000 and func_code in {011000, 011001, 011010, 011011}.
  - mem_stall: (mem_read|mem_write) & waitrequest, evaluated only in FETCH_INSTR and MEMORY_ACCESS.
- Transitions, registered on the rising edge:
  - FETCH_INSTR: if mem_stall, hold; else go to DECODE.
  - DECODE: go to EXECUTE. Always one cycle.
  - EXECUTE, non-MD instruction: go to MEMORY_ACCESS after one cycle.
  - EXECUTE, MD instruction:
    - First EXECUTE cycle: drive md_start=1 combinationally, set md_started, hold.
    - Later cycles: hold while md_busy=1. In the first cycle after md_busy falls, go to MEMORY_ACCESS and clear md_started.
    - The bench must see at least two EXECUTE cycles for any MD instruction.
  - MEMORY_ACCESS: if mem_stall, hold. Otherwise:
    - is_load: go to WRITE_BACK.
    - not is_load: the instruction retires here. If halt_req, go to HALT; else go to FETCH_INSTR.
  - WRITE_BACK: the instruction retires. If halt_req, go to HALT; else go to FETCH_INSTR. Always one cycle.
  - HALT: terminal until reset. active=0, stall=0, instr_count frozen.
- stall=1 exactly on cycles where the state is held in a non-HALT state.
- instr_count increments by 1 on each retiring transition and wraps modulo 2^CNT_W.
- halt_req is sampled only on retiring transitions and is ignored in all other states.
- A halt_req and a mem_stall in the same MEMORY_ACCESS cycle: the stall wins. The halt is taken on the cycle the transfer completes, provided halt_req is still asserted.
- Minimum latency per instruction: non-load = 4 cycles; load = 5 cycles. Add stall cycles to these.
- An undefined opcode follows the non-load path.

Optional Feature:
- Macro: SEQ_WAIT_WATCHDOG_EN.
- Enabled:
  - A wait counter increments on each mem_stall cycle and clears on any cycle without a stall.
  - When the counter would reach WAIT_TIMEOUT, the next state is HALT instead of a hold, and bus_error is set to 1 sticky until reset.
  - instr_count does not increment on this transition.
- Disabled: no counter is built, bus_error is constant 0, and mem_stall holds indefinitely.

Test Plan:
- ADDU (opcode 0, func 100001), no waitrequest: states 0,1,2,3,0 over 4 cycles; instr_count 0→1.
- LW (opcode 100011) with waitrequest high for 3 cycles in MEMORY_ACCESS: state 3 held for 4 cycles with stall=1 on the first 3, then 4, then 0. Total 8 cycles; instr_count increments once.
- MULT (func 011000) with md_busy high for 5 cycles after md_start: md_start is high exactly in the first EXECUTE cycle; EXECUTE lasts 7 cycles; then 3, then 0.
- JR with halt_req=1 during MEMORY_ACCESS: state goes 3→5, active=0, and instr_count is frozen for 20 further cycles regardless of inputs.
- Reset asserted mid-FETCH while waitrequest=1: next cycle state=0, stall=0, instr_count=0, active=1.
- With SEQ_WAIT_WATCHDOG_EN and WAIT_TIMEOUT=8, hold waitrequest high in FETCH: after 8 stall cycles state=5, bus_error=1, active=0. Without the macro, FETCH is still held at cycle 100.
